// File: rtl/wb_i2c_xfer_sequencer.sv
// wb_i2c_xfer_sequencer: Wishbone master that drives an iicmb_m_wb I2C controller.
// Turns single-byte read/write requests into Start / address / data / Stop
// command sequences and returns the read byte plus a completion status.
// Build option: define WB_SEQ_POLL_EN to poll CMDR instead of waiting on irq_i
// (CSR is then programmed with the interrupt enable cleared).
module wb_i2c_xfer_sequencer #(
  parameter logic [4:0]  BUS_ID         = 5'h05,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_op,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_status,
  output logic       cyc_o,
  output logic       stb_o,
  output logic       we_o,
  output logic [1:0] adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  input  logic       ack_i,
  input  logic       irq_i
);

  localparam logic [3:0] S_INIT_CSR = 4'd0,  S_INIT_DPR = 4'd1,  S_INIT_CMD = 4'd2,
                         S_IDLE     = 4'd3,  S_START    = 4'd4,  S_ADDR_DPR = 4'd5,
                         S_ADDR_CMD = 4'd6,  S_DATA_DPR = 4'd7,  S_DATA_CMD = 4'd8,
                         S_RDNAK    = 4'd9,  S_RDDPR    = 4'd10, S_STOP     = 4'd11,
                         S_WAIT     = 4'd12, S_RESP     = 4'd13;

  localparam logic [1:0] A_CSR = 2'd0, A_DPR = 2'd1, A_CMDR = 2'd2;
  localparam logic [1:0] ST_OK = 2'b00, ST_NAK = 2'b01, ST_ERR = 2'b10, ST_TMO = 2'b11;

`ifdef WB_SEQ_POLL_EN
  localparam logic [7:0] CSR_VAL = 8'h80;
`else
  localparam logic [7:0] CSR_VAL = 8'hC0;
`endif

  logic [3:0]  state, ret_state;
  logic        op_r, rerun_init;
  logic [6:0]  addr_r;
  logic [7:0]  data_r;
  logic [31:0] tmo_cnt;
  logic        acc_en, acc_we, tmo_hit, in_init;
  logic [1:0]  acc_adr;
  logic [7:0]  acc_dat;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  // A stalled access or a completion that never arrives both end here.
  assign tmo_hit   = (tmo_cnt >= TIMEOUT_CYCLES) && !(cyc_o && ack_i);
  // Failures during init have no requester, so they just restart init.
  assign in_init   = (state == S_INIT_CSR) || (state == S_INIT_DPR) || (state == S_INIT_CMD) ||
                     (state == S_WAIT && ret_state == S_IDLE);

  // Register access each state performs; WAIT reads CMDR for completion bits.
  always_comb begin
    acc_en  = 1'b1;
    acc_we  = 1'b1;
    acc_adr = A_CMDR;
    acc_dat = 8'h00;
    case (state)
      S_INIT_CSR: begin acc_adr = A_CSR; acc_dat = CSR_VAL; end
      S_INIT_DPR: begin acc_adr = A_DPR; acc_dat = {3'b000, BUS_ID}; end
      S_INIT_CMD: acc_dat = 8'h06;
      S_START:    acc_dat = 8'h04;
      S_ADDR_DPR: begin acc_adr = A_DPR; acc_dat = {addr_r, op_r}; end
      S_ADDR_CMD: acc_dat = 8'h01;
      S_DATA_DPR: begin acc_adr = A_DPR; acc_dat = data_r; end
      S_DATA_CMD: acc_dat = 8'h01;
      S_RDNAK:    acc_dat = 8'h03;
      S_RDDPR:    begin acc_adr = A_DPR; acc_we = 1'b0; end
      S_STOP:     acc_dat = 8'h05;
`ifdef WB_SEQ_POLL_EN
      S_WAIT:     acc_we = 1'b0;
`else
      S_WAIT:     begin acc_we = 1'b0; acc_en = irq_i; end
`endif
      default:    acc_en = 1'b0;
    endcase
  end

  // Sequencer: launches one access at a time, steps on ack, handles errors.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_INIT_CSR;
      ret_state  <= S_IDLE;
      cyc_o      <= 1'b0;
      stb_o      <= 1'b0;
      we_o       <= 1'b0;
      adr_o      <= 2'd0;
      dat_o      <= 8'h00;
      op_r       <= 1'b0;
      addr_r     <= 7'h00;
      data_r     <= 8'h00;
      rsp_data   <= 8'h00;
      rsp_status <= ST_OK;
      rerun_init <= 1'b0;
      tmo_cnt    <= 32'd0;
    end else if (tmo_hit) begin
      cyc_o   <= 1'b0;
      stb_o   <= 1'b0;
      tmo_cnt <= 32'd0;
      if (in_init) state <= S_INIT_CSR;
      else begin
        rsp_status <= ST_TMO;
        rsp_data   <= 8'h00;
        rerun_init <= 1'b1;
        state      <= S_RESP;
      end
    end else begin
      tmo_cnt <= (state == S_IDLE || state == S_RESP) ? 32'd0 : tmo_cnt + 32'd1;
      // cyc_o is low for at least one cycle after every ack before relaunch
      if (acc_en && !cyc_o) begin
        cyc_o <= 1'b1;
        stb_o <= 1'b1;
        we_o  <= acc_we;
        adr_o <= acc_adr;
        dat_o <= acc_dat;
      end
      if (cyc_o && ack_i) begin
        cyc_o <= 1'b0;
        stb_o <= 1'b0;
        // an empty status poll keeps the running completion timeout
        if (!(state == S_WAIT && dat_i[7:4] == 4'h0)) tmo_cnt <= 32'd0;
        case (state)
          S_INIT_CSR: state <= S_INIT_DPR;
          S_INIT_DPR: state <= S_INIT_CMD;
          S_INIT_CMD: begin state <= S_WAIT; ret_state <= S_IDLE; end
          S_START:    begin state <= S_WAIT; ret_state <= S_ADDR_DPR; end
          S_ADDR_DPR: state <= S_ADDR_CMD;
          S_ADDR_CMD: begin state <= S_WAIT; ret_state <= op_r ? S_RDNAK : S_DATA_DPR; end
          S_DATA_DPR: state <= S_DATA_CMD;
          S_DATA_CMD: begin state <= S_WAIT; ret_state <= S_STOP; end
          S_RDNAK:    begin state <= S_WAIT; ret_state <= S_RDDPR; end
          S_RDDPR:    begin rsp_data <= dat_i; state <= S_STOP; end
          S_STOP:     begin state <= S_WAIT; ret_state <= S_RESP; end
          S_WAIT: begin
            if (dat_i[5] || dat_i[4]) begin
              // AL leaves the bus to the winner (no Stop); ERR also reinitialises
              if (in_init) state <= S_INIT_CSR;
              else begin
                rsp_status <= ST_ERR;
                rsp_data   <= 8'h00;
                rerun_init <= dat_i[4];
                state      <= S_RESP;
              end
            end else if (dat_i[6]) begin
              if (in_init) state <= S_INIT_CSR;
              else if (ret_state == S_RESP) state <= S_RESP;
              else begin
                rsp_status <= ST_NAK;
                rsp_data   <= 8'h00;
                state      <= S_STOP;
              end
            end else if (dat_i[7]) begin
              state <= ret_state;
            end
          end
          default: ;
        endcase
      end
      if (state == S_IDLE && req_valid) begin
        op_r       <= req_op;
        addr_r     <= req_addr;
        data_r     <= req_data;
        rsp_data   <= 8'h00;
        rsp_status <= ST_OK;
        state      <= S_START;
      end
      if (state == S_RESP && rsp_ready) begin
        state      <= rerun_init ? S_INIT_CSR : S_IDLE;
        rerun_init <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_i2c_xfer_sequencer.sv
// Directed bench for wb_i2c_xfer_sequencer with a small iicmb-like Wishbone slave.
// Slave answers one slave address (7'h22); reads return 8'h64.
module tb_wb_i2c_xfer_sequencer;
  localparam int TMO = 100;

  logic clk = 1'b0, rst_i = 1'b1;
  logic req_valid = 1'b0, req_op = 1'b0, rsp_ready = 1'b0;
  logic [6:0] req_addr = 7'h00;
  logic [7:0] req_data = 8'h00;
  logic req_ready, rsp_valid, cyc_o, stb_o, we_o;
  logic [7:0] rsp_data, dat_o;
  logic [1:0] rsp_status, adr_o;
  logic [7:0] dat_i = 8'h00;
  logic ack_i = 1'b0, irq_i = 1'b0;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  wb_i2c_xfer_sequencer #(.BUS_ID(5'h05), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i)
  );

  // Slave model: registered ack, log of acked accesses {we, adr, wdata}
  logic [10:0] log_mem [0:511];
  int log_n = 0;
  logic block_ack = 1'b0;
  logic [7:0] dpr = 8'h00, cmd_st = 8'h00;
  logic after_start = 1'b0;
  int dly = 0;

  always @(posedge clk) begin
    if (rst_i) begin
      ack_i <= 1'b0; irq_i <= 1'b0; dly <= 0; after_start <= 1'b0;
    end else begin
      ack_i <= 1'b0;
      if (dly != 0) begin
        dly <= dly - 1;
        if (dly == 1) irq_i <= 1'b1;
      end
      if (cyc_o && stb_o && !ack_i && !block_ack) begin
        ack_i <= 1'b1;
        if (log_n < 512) log_mem[log_n] <= {we_o, adr_o, we_o ? dat_o : 8'h00};
        log_n <= log_n + 1;
        dat_i <= 8'h00;
        if (we_o) begin
          if (adr_o == 2'd1) dpr <= dat_o;
          if (adr_o == 2'd2) begin
            dly <= 3;
            cmd_st <= 8'h80;
            if (dat_o == 8'h04) after_start <= 1'b1;
            if (dat_o == 8'h01) begin
              after_start <= 1'b0;
              if (after_start && dpr[7:1] != 7'h22) cmd_st <= 8'h40;
            end
          end
        end else begin
          if (adr_o == 2'd2) begin dat_i <= cmd_st; irq_i <= 1'b0; end
          else if (adr_o == 2'd1) dat_i <= 8'h64;
        end
      end
    end
  end

  // Protocol monitor sampled mid-cycle
  int viol = 0;
  logic p_cyc = 1'b0, p_ack = 1'b0;
  logic [10:0] p_acc = 11'h0;
  always @(negedge clk) begin
    if (!rst_i)
      viol <= viol + int'(p_cyc && p_ack && cyc_o)
                   + int'(p_cyc && !p_ack && cyc_o && (p_acc !== {we_o, adr_o, dat_o}))
                   + int'(cyc_o !== stb_o) + int'(req_ready && rsp_valid);
    p_cyc <= cyc_o;
    p_ack <= ack_i;
    p_acc <= {we_o, adr_o, dat_o};
  end

  task automatic send_req(input logic op, input logic [6:0] a, input logic [7:0] d, output bit ok);
    int n;
    n = 0;
    req_op = op; req_addr = a; req_data = d; req_valid = 1'b1;
    while (!req_ready && n < 500) begin @(negedge clk); n++; end
    ok = req_ready;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 1000) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({cyc_o, stb_o, we_o, adr_o, dat_o} !== 13'h0) begin
      errors++; $display("FAIL reset_wb got %h want 0", {cyc_o, stb_o, we_o, adr_o, dat_o});
    end
    checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_status} !== 12'h0) begin
      errors++; $display("FAIL reset_hs got %h want 0", {req_ready, rsp_valid, rsp_data, rsp_status});
    end
  endtask

  task automatic test_init();
    int base, n;
    logic [10:0] exp [4];
    exp = '{11'h4C0, 11'h505, 11'h606, 11'h200};
    base = log_n; n = 0;
    rst_i = 1'b0;
    while (!req_ready && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL init_ready got %b want 1", req_ready); end
    checks++;
    if (log_n - base !== 4) begin errors++; $display("FAIL init_count got %0d want 4", log_n - base); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_mem[base + i] !== exp[i]) begin
        errors++; $display("FAIL init_acc%0d got %h want %h", i, log_mem[base + i], exp[i]);
      end
    end
  endtask

  task automatic test_write();
    int base, n; bit ok;
    logic [10:0] exp [10];
    exp = '{11'h604, 11'h200, 11'h544, 11'h601, 11'h200, 11'h51F, 11'h601, 11'h200, 11'h605, 11'h200};
    base = log_n;
    send_req(1'b0, 7'h22, 8'h1F, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wr_accept got %b want 1", ok); end
    wait_rsp(n);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_rsp got %b want 1", rsp_valid); end
    checks++; if (rsp_status !== 2'b00) begin errors++; $display("FAIL wr_status got %b want 00", rsp_status); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL wr_data got %h want 00", rsp_data); end
    checks++; if (log_n - base !== 10) begin errors++; $display("FAIL wr_count got %0d want 10", log_n - base); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (log_mem[base + i] !== exp[i]) begin
        errors++; $display("FAIL wr_acc%0d got %h want %h", i, log_mem[base + i], exp[i]);
      end
    end
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++; $display("FAIL wr_done got %b want 01", {rsp_valid, req_ready});
    end
  endtask

  task automatic test_read_hold();
    int base, n; bit ok;
    logic [10:0] exp [10];
    exp = '{11'h604, 11'h200, 11'h545, 11'h601, 11'h200, 11'h603, 11'h200, 11'h100, 11'h605, 11'h200};
    base = log_n;
    send_req(1'b1, 7'h22, 8'hAA, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rd_accept got %b want 1", ok); end
    wait_rsp(n);
    checks++; if (rsp_status !== 2'b00) begin errors++; $display("FAIL rd_status got %b want 00", rsp_status); end
    checks++; if (rsp_data !== 8'h64) begin errors++; $display("FAIL rd_data got %h want 64", rsp_data); end
    checks++; if (log_n - base !== 10) begin errors++; $display("FAIL rd_count got %0d want 10", log_n - base); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (log_mem[base + i] !== exp[i]) begin
        errors++; $display("FAIL rd_acc%0d got %h want %h", i, log_mem[base + i], exp[i]);
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if ({rsp_valid, req_ready, rsp_data} !== 10'b10_0110_0100) begin
      errors++; $display("FAIL rd_hold got %b want 1001100100", {rsp_valid, req_ready, rsp_data});
    end
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++; $display("FAIL rd_done got %b want 01", {rsp_valid, req_ready});
    end
  endtask

  task automatic test_nak();
    int base, n; bit ok;
    logic [10:0] exp [7];
    exp = '{11'h604, 11'h200, 11'h566, 11'h601, 11'h200, 11'h605, 11'h200};
    base = log_n;
    send_req(1'b0, 7'h33, 8'h5A, ok);
    wait_rsp(n);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL nak_rsp got %b want 1", rsp_valid); end
    checks++; if (rsp_status !== 2'b01) begin errors++; $display("FAIL nak_status got %b want 01", rsp_status); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL nak_data got %h want 00", rsp_data); end
    checks++; if (log_n - base !== 7) begin errors++; $display("FAIL nak_count got %0d want 7", log_n - base); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (log_mem[base + i] !== exp[i]) begin
        errors++; $display("FAIL nak_acc%0d got %h want %h", i, log_mem[base + i], exp[i]);
      end
    end
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++; $display("FAIL nak_done got %b want 01", {rsp_valid, req_ready});
    end
  endtask

  task automatic test_timeout();
    int base, n; bit ok;
    logic [10:0] exp [4];
    exp = '{11'h4C0, 11'h505, 11'h606, 11'h200};
    block_ack = 1'b1;
    base = log_n;
    send_req(1'b0, 7'h22, 8'h1F, ok);
    wait_rsp(n);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL tmo_rsp got %b want 1", rsp_valid); end
    checks++; if (rsp_status !== 2'b11) begin errors++; $display("FAIL tmo_status got %b want 11", rsp_status); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL tmo_data got %h want 00", rsp_data); end
    checks++;
    if (n < TMO - 5 || n > TMO + 10) begin errors++; $display("FAIL tmo_latency got %0d want about %0d", n, TMO); end
    checks++; if (cyc_o !== 1'b0) begin errors++; $display("FAIL tmo_cyc got %b want 0", cyc_o); end
    checks++; if (log_n !== base) begin errors++; $display("FAIL tmo_noacc got %0d want %0d", log_n, base); end
    block_ack = 1'b0;
    rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, req_ready} !== 2'b00) begin
      errors++; $display("FAIL tmo_reinit got %b want 00", {rsp_valid, req_ready});
    end
    base = log_n; n = 0;
    while (!req_ready && n < 300) begin @(negedge clk); n++; end
    checks++; if (log_n - base !== 4) begin errors++; $display("FAIL tmo_init_count got %0d want 4", log_n - base); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_mem[base + i] !== exp[i]) begin
        errors++; $display("FAIL tmo_init%0d got %h want %h", i, log_mem[base + i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int base, n, seen; bit ok;
    logic [10:0] exp [4];
    exp = '{11'h4C0, 11'h505, 11'h606, 11'h200};
    base = log_n; n = 0;
    send_req(1'b0, 7'h22, 8'h1F, ok);
    while (log_n < base + 7 && n < 500) begin @(negedge clk); n++; end
    while (!(cyc_o && !we_o) && n < 600) begin @(negedge clk); n++; end
    checks++; if (cyc_o !== 1'b1) begin errors++; $display("FAIL rst_mid_reach got %b want 1", cyc_o); end
    rst_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({cyc_o, stb_o, we_o, adr_o, dat_o} !== 13'h0) begin
      errors++; $display("FAIL rst_mid_wb got %h want 0", {cyc_o, stb_o, we_o, adr_o, dat_o});
    end
    checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_status} !== 12'h0) begin
      errors++; $display("FAIL rst_mid_hs got %h want 0", {req_ready, rsp_valid, rsp_data, rsp_status});
    end
    rst_i = 1'b0;
    base = log_n; n = 0; seen = 0;
    while (!req_ready && n < 300) begin
      @(negedge clk); n++;
      if (rsp_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_stale got %0d want 0", seen); end
    checks++; if (log_n - base !== 4) begin errors++; $display("FAIL rst_mid_count got %0d want 4", log_n - base); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_mem[base + i] !== exp[i]) begin
        errors++; $display("FAIL rst_mid_init%0d got %h want %h", i, log_mem[base + i], exp[i]);
      end
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL protocol got %0d violations want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_write();
    test_read_hold();
    test_nak();
    test_timeout();
    test_write();
    test_reset_mid();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
